team_06_i2s_rx_ctrl: RTL and testbench
======================================

# team_06_i2s_rx_ctrl

Master-mode I2S receive controller for the team_06 audio front end. It generates the serial bit clock (SCK) and word select (WS) for the external I2S ADC/microphone, and sequences start-up, warm-up and shutdown. It deserializes each slot into a signed sample and delivers samples downstream over a one-entry valid/ready register with sticky overrun reporting.

## Interface
- `CLK_DIV`, default 4: `clk` cycles per SCK half-period; must be ≥ 2.
- `SAMPLE_W`, default 16: sample width in bits, 1..31.
- `WARMUP_FRAMES`, default 2: complete frames discarded after enable; 0 means no warm-up.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: level request to run the interface.
- `sd_in` in 1: serial data from the ADC, MSB first.
- `sck` out 1: I2S bit clock.
- `ws` out 1: word select; 0 = left slot, 1 = right slot.
- `sample` out SAMPLE_W: signed captured sample.
- `sample_ch` out 1: channel of `sample`.
- `sample_valid` out 1: `sample` holds an undelivered word.
- `sample_ready` in 1: downstream accepts the word.
- `clr_overrun` in 1: one-cycle clear of `overrun`.
- `overrun` out 1: sticky flag; a completed sample was dropped.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `sck`=0, `ws`=0, all counters zero. `enable`=1 moves to WARMUP, or to RUN if `WARMUP_FRAMES`=0.
  - WARMUP: clocks run and no samples are delivered. After `WARMUP_FRAMES` complete frames, move to RUN.
  - RUN: samples are delivered.
  - STOP: entered from WARMUP or RUN when `enable`=0. Clocks keep running until the end of the current right slot (falling SCK after bit 31 with `ws`=1), then move to IDLE. `enable` is ignored while in STOP.
- SCK: the divider counts 0..`CLK_DIV`-1 and toggles `sck` at the terminal count. It runs only outside IDLE. Rise and fall are internal one-cycle pulses.
- Slot: 32 SCK periods; bit index 0..31 advances on each SCK rise. A frame is a left slot followed by a right slot.
- WS toggles on the SCK fall that follows bit 31.
- Capture:
  - Bit 0 is the I2S delay bit and is discarded.
  - Bits 1..`SAMPLE_W` are shifted into an internal register MSB first, sampling `sd_in` on the rise pulse.
  - Remaining bits are ignored.
  - The sample completes on the rise of bit 31. Samples completing in RUN or STOP are offered downstream; samples completing in WARMUP are not.
- Output register:
  - Empty, sample completes: load it; `sample_valid`=1.
  - `sample_valid`&&`sample_ready`: consumed. If a new sample completes in the same cycle, it is loaded and `sample_valid` stays 1 with no overrun.
  - `sample_valid`&&!`sample_ready` when a sample completes: the new sample is dropped, the old one is held, and `overrun`=1.
  - `overrun` clears on `clr_overrun`. If a set and `clr_overrun` occur in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values immediately. The next `enable` starts with a full warm-up.

## Timing
- Reset values: `sck`=0, `ws`=0, `sample`=0, `sample_ch`=0, `sample_valid`=0, `overrun`=0, `busy`=0.
- IDLE→WARMUP/RUN: 1 cycle after `enable` is sampled high. The first SCK rise occurs `CLK_DIV` cycles later.
- SCK period is 2·`CLK_DIV` cycles; a frame is 128·`CLK_DIV` cycles.
- `sample_valid` rises 1 cycle after the rise pulse of bit 31.
- `sample_valid` falls 1 cycle after handshake, unless it is reloaded in that cycle.
- `busy` falls in the same cycle that IDLE is entered.

## Configuration
- `TEAM_06_I2S_STEREO_EN` defined: both slots are delivered, and `sample_ch` = `ws` value of the slot that produced the sample.
- `TEAM_06_I2S_STEREO_EN` undefined: only left-slot samples are delivered, and `sample_ch` is tied to 0. Right-slot data is shifted but never loaded or counted toward overrun.

## Structure
- Package `team_06_i2s_pkg`: state enum (IDLE, WARMUP, RUN, STOP), `SLOT_BITS`=32, `FRAME_SLOTS`=2.
- Sub-module `team_06_i2s_sck_gen`: `CLK_DIV` divider producing `sck` and the rise/fall pulses, with a run input.

## Test plan
Bench setup: `CLK_DIV`=2, `SAMPLE_W`=16, `WARMUP_FRAMES`=1, and an I2S ADC model sending left=0x8001, right=0x1234.
- Hold `rst_n`=0 with random inputs → every output equals its reset value; `sck` stays static.
- Set `enable`=1, `sample_ready`=1, macro undefined → no valid during frame 1. From frame 2 on, one valid per frame with `sample`=0x8001 (−32767) and `sample_ch`=0, 1 cycle after the bit-31 rise.
- Same stimulus with `TEAM_06_I2S_STEREO_EN` → valids alternate 0x8001/ch0 and 0x1234/ch1, 64·`CLK_DIV` cycles apart.
- Hold `sample_ready`=0 across two completions → first sample held, `overrun`=1 at the second. Pulse `clr_overrun` → `overrun`=0; `sample` remains 0x8001.
- Drop `enable` during a left slot → left sample still delivered, `sck` runs to the end of the right slot, then `busy`=0 and `sck`=0. Re-assert → warm-up repeats.
- Pulse `rst_n` low mid-slot → outputs reset asynchronously in the same cycle; no partial sample is ever delivered.

Source files
------------

// File: rtl/team_06_i2s_pkg.sv
// team_06_i2s_pkg: shared state type and slot/frame geometry for the
// team_06 I2S receive controller.
package team_06_i2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        RUN,
        STOP
    } state_t;

    localparam int SLOT_BITS   = 32;
    localparam int FRAME_SLOTS = 2;
    localparam int BIT_W       = $clog2(SLOT_BITS);

endpackage

// File: rtl/team_06_i2s_sck_gen.sv
// team_06_i2s_sck_gen: divides clk down to the I2S bit clock. The counter runs
// 0..CLK_DIV-1 and sck toggles at the terminal count, so one SCK period is
// 2*CLK_DIV cycles. rise/fall are one-cycle pulses in the cycle whose closing
// edge moves sck high/low, i.e. the edge on which the receiver samples sd_in.
module team_06_i2s_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick;

    assign tick = run && (cnt == CNT_LAST);
    assign rise = tick && !sck;
    assign fall = tick && sck;

    // Divider and bit clock; both park at zero whenever the interface is stopped.
    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!run) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (tick) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/team_06_i2s_rx_ctrl.sv
// team_06_i2s_rx_ctrl: master-mode I2S receiver. Generates sck/ws, sequences
// IDLE -> WARMUP -> RUN -> STOP, deserializes each 32-bit slot (bit 0 is the
// I2S delay bit, bits 1..SAMPLE_W are the sample MSB first) and offers samples
// through a one-entry valid/ready register with a sticky overrun flag.
// Build option TEAM_06_I2S_STEREO_EN: deliver both slots with sample_ch = ws;
// when undefined only left-slot samples are delivered and sample_ch is 0.
module team_06_i2s_rx_ctrl
    import team_06_i2s_pkg::*;
#(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_W      = 16,
    parameter int WARMUP_FRAMES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic                       sd_in,
    output logic                       sck,
    output logic                       ws,
    output logic signed [SAMPLE_W-1:0] sample,
    output logic                       sample_ch,
    output logic                       sample_valid,
    input  logic                       sample_ready,
    input  logic                       clr_overrun,
    output logic                       overrun,
    output logic                       busy
);

    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_BITS - 1);
    localparam logic [BIT_W-1:0] CAP_LAST = BIT_W'(SAMPLE_W);
    localparam int               WARM_W   = (WARMUP_FRAMES > 1) ? $clog2(WARMUP_FRAMES) : 1;
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'((WARMUP_FRAMES > 0) ? WARMUP_FRAMES - 1 : 0);

    state_t              state, next_state;
    logic                sck_rise, sck_fall;
    logic [BIT_W-1:0]    bit_cnt;
    logic [WARM_W-1:0]   warm_cnt;
    logic [SAMPLE_W-1:0] shreg, shreg_next;
    logic                capture_bit, slot_done, frame_end, slot_ok, offer;

    assign busy = (state != IDLE);

    team_06_i2s_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (busy),
        .sck  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    // The slot's last data bit can land on bit 31 itself, so the completed word
    // is taken from the shift value including this rise's capture.
    assign capture_bit = sck_rise && (bit_cnt != '0) && (bit_cnt <= CAP_LAST);
    assign shreg_next  = capture_bit ? ((shreg << 1) | SAMPLE_W'(sd_in)) : shreg;
    assign slot_done   = sck_rise && (bit_cnt == LAST_BIT);
    // bit_cnt has already wrapped to 0 on the fall that follows bit 31.
    assign frame_end   = sck_fall && (bit_cnt == '0) && ws;

`ifdef TEAM_06_I2S_STEREO_EN
    assign slot_ok = 1'b1;
`else
    assign slot_ok = !ws;
`endif

    assign offer = slot_done && slot_ok && ((state == RUN) || (state == STOP));

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode; a stop request landing on a frame boundary goes straight to IDLE.
    // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (enable) next_state = (WARMUP_FRAMES == 0) ? RUN : WARMUP;
            WARMUP:  if (!enable)                                   next_state = frame_end ? IDLE : STOP;
                     else if (frame_end && (warm_cnt == WARM_LAST)) next_state = RUN;
            RUN:     if (!enable) next_state = frame_end ? IDLE : STOP;
            STOP:    if (frame_end) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Bit index, word select and warm-up frame counter; all held at zero in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            ws       <= 1'b0;
            warm_cnt <= '0;
        end else if (state == IDLE) begin
            bit_cnt  <= '0;
            ws       <= 1'b0;
            warm_cnt <= '0;
        end else begin
            if (sck_rise)                 bit_cnt <= bit_cnt + BIT_W'(1);
            if (sck_fall && bit_cnt == '0) ws     <= ~ws;
            if (state != WARMUP)          warm_cnt <= '0;
            else if (frame_end)           warm_cnt <= warm_cnt + WARM_W'(1);
        end
    end

    // Deserializer; every slot overwrites all SAMPLE_W bits, so no per-slot clear is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shreg <= '0;
        else        shreg <= shreg_next;
    end

    // One-entry output register: load when empty or draining, otherwise drop the new word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample       <= '0;
            sample_valid <= 1'b0;
`ifdef TEAM_06_I2S_STEREO_EN
            sample_ch    <= 1'b0;
`endif
        end else if (offer && (!sample_valid || sample_ready)) begin
            sample       <= shreg_next;
            sample_valid <= 1'b1;
`ifdef TEAM_06_I2S_STEREO_EN
            sample_ch    <= ws;
`endif
        end else if (sample_valid && sample_ready) begin
            sample_valid <= 1'b0;
        end
    end

`ifndef TEAM_06_I2S_STEREO_EN
    assign sample_ch = 1'b0;
`endif

    // Sticky overrun; a new drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                       overrun <= 1'b0;
        else if (offer && sample_valid && !sample_ready)  overrun <= 1'b1;
        else if (clr_overrun)                             overrun <= 1'b0;
    end

endmodule

// File: tb/tb_team_06_i2s_rx_ctrl.sv
// tb_team_06_i2s_rx_ctrl: bench for team_06_i2s_rx_ctrl with CLK_DIV=2,
// SAMPLE_W=16, WARMUP_FRAMES=1 and an I2S ADC model sending left=0x8001,
// right=0x1234. Expected samples are queued as each slot starts and compared
// when the slot completes.
module tb_team_06_i2s_rx_ctrl;

    localparam int          CLK_DIV       = 2;
    localparam int          SAMPLE_W      = 16;
    localparam int          WARMUP_FRAMES = 1;
    localparam logic [15:0] LEFT_WORD     = 16'h8001;
    localparam logic [15:0] RIGHT_WORD    = 16'h1234;
`ifdef TEAM_06_I2S_STEREO_EN
    localparam bit          STEREO        = 1'b1;
`else
    localparam bit          STEREO        = 1'b0;
`endif
    localparam int          SLOT_CYC      = 64 * CLK_DIV;
    localparam int          GAP           = STEREO ? SLOT_CYC : 2 * SLOT_CYC;
    // enable edge -> state change (1) + first rise (CLK_DIV) + 95 more SCK periods + poll (1)
    localparam int          FIRST_LAT     = 2 + CLK_DIV + 95 * 2 * CLK_DIV;
    localparam logic [15:0] HELD_WORD     = STEREO ? RIGHT_WORD : LEFT_WORD;

    logic                       clk = 1'b0;
    logic                       rst_n, enable, sd_in, sample_ready, clr_overrun;
    logic                       sck, ws, sample_ch, sample_valid, overrun, busy;
    logic signed [SAMPLE_W-1:0] sample;

    team_06_i2s_rx_ctrl #(
        .CLK_DIV      (CLK_DIV),
        .SAMPLE_W     (SAMPLE_W),
        .WARMUP_FRAMES(WARMUP_FRAMES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .sd_in       (sd_in),
        .sck         (sck),
        .ws          (ws),
        .sample      (sample),
        .sample_ch   (sample_ch),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .clr_overrun (clr_overrun),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        ch;
        logic        deliver;
    } exp_t;

    typedef struct {
        logic        en;
        logic        sd;
        logic        rdy;
        logic        clr;
        logic [15:0] exp_sample;
        logic [5:0]  exp_flags;   // {sck, ws, sample_ch, sample_valid, overrun, busy}
    } rst_vec_t;

    exp_t     exp_q[$];
    rst_vec_t vecs[6];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   ncyc = 0;
    int   deliveries = 0;
    int   rc = 0;
    int   last_rc = 0;
    int   last_del_cyc = -1;
    bit   prev_sck = 1'b0;
    bit   chk_en = 1'b0;
    logic sd_idle = 1'b0;

    int          m_bidx, m_slot, m_nb, m_nslot;
    bit          m_done;
    exp_t        m_e;
    logic [15:0] m_word;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ADC model and scoreboard, evaluated on the falling clk edge.
    always @(negedge clk) begin
        ncyc++;
        m_done = 1'b0;
        if (!busy) begin
            rc           = 0;
            prev_sck     = 1'b0;
            last_del_cyc = -1;
            exp_q.delete();
            sd_in        = sd_idle;
        end else begin
            if (sck && !prev_sck) begin
                rc++;
                m_bidx = (rc - 1) % 32;
                m_slot = ((rc - 1) / 32) % 2;
                if (m_bidx == 0) begin
                    check("ws_slot", 32'(ws), 32'(m_slot));
                    m_e.data    = (m_slot == 1) ? RIGHT_WORD : LEFT_WORD;
                    m_e.ch      = (m_slot == 1);
                    m_e.deliver = (((rc - 1) / 64) >= WARMUP_FRAMES) && (STEREO || m_slot == 0);
                    exp_q.push_back(m_e);
                end
                if (m_bidx == 31) begin
                    if (exp_q.size() == 0) begin
                        check("sb_nonempty", 32'(exp_q.size()), 32'd1);
                    end else begin
                        m_e = exp_q.pop_front();
                        if (m_e.deliver) begin
                            m_done = 1'b1;
                            deliveries++;
                            if (chk_en) begin
                                check("sample", {16'h0, sample}, {16'h0, m_e.data});
                                check("sample_ch", 32'(sample_ch), 32'(m_e.ch));
                            end
                            if (last_del_cyc >= 0) check("valid_gap", 32'(ncyc - last_del_cyc), 32'(GAP));
                            last_del_cyc = ncyc;
                        end
                    end
                end
            end
            prev_sck = sck;
            last_rc  = rc;
            m_nb     = rc % 32;
            m_nslot  = (rc / 32) % 2;
            m_word   = (m_nslot == 1) ? RIGHT_WORD : LEFT_WORD;
            sd_in    = (m_nb >= 1 && m_nb <= SAMPLE_W) ? m_word[SAMPLE_W - m_nb] : 1'b1;
        end
        if (chk_en) check("valid_cycle", 32'(sample_valid), 32'(m_done));
    end

    initial begin
        int n, t0, d0;

        for (int i = 0; i < 6; i++) begin
            vecs[i].en         = 1'($urandom);
            vecs[i].sd         = 1'($urandom);
            vecs[i].rdy        = 1'($urandom);
            vecs[i].clr        = 1'($urandom);
            vecs[i].exp_sample = 16'h0000;
            vecs[i].exp_flags  = 6'b000000;
        end

        rst_n        = 1'b0;
        enable       = 1'b0;
        sample_ready = 1'b0;
        clr_overrun  = 1'b0;

        // Reset held with random inputs: outputs stay at reset values.
        for (int i = 0; i < 6; i++) begin
            enable       = vecs[i].en;
            sd_idle      = vecs[i].sd;
            sample_ready = vecs[i].rdy;
            clr_overrun  = vecs[i].clr;
            repeat (3) tick();
            check("rst_flags", 32'({sck, ws, sample_ch, sample_valid, overrun, busy}), 32'(vecs[i].exp_flags));
            check("rst_sample", {16'h0, sample}, {16'h0, vecs[i].exp_sample});
        end

        enable       = 1'b0;
        sample_ready = 1'b1;
        clr_overrun  = 1'b0;
        sd_idle      = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        check("idle_after_rst", 32'({sck, ws, busy}), 32'd0);
        chk_en = 1'b1;

        // Start-up latency: busy one cycle after enable, first SCK rise CLK_DIV later.
        enable = 1'b1;
        tick();
        check("start_busy", 32'(busy), 32'd1);
        check("start_sck_a", 32'(sck), 32'd0);
        tick();
        check("start_sck_b", 32'(sck), 32'd0);
        tick();
        check("first_rise", 32'(sck), 32'd1);

        // Normal streaming with sample_ready=1.
        for (n = 0; n < 1200 && deliveries < 3; n++) tick();
        check("three_deliv", 32'(deliveries >= 3), 32'd1);

        // Overrun: hold sample_ready low across two completions.
        d0 = deliveries;
        for (n = 0; n < 300 && deliveries == d0; n++) tick();
        check("ovr_sync", 32'(deliveries != d0), 32'd1);
        chk_en       = 1'b0;
        sample_ready = 1'b0;
        for (n = 0; n < 300 && !sample_valid; n++) tick();
        check("ovr_first_valid", 32'(sample_valid), 32'd1);
        check("ovr_first_noflag", 32'(overrun), 32'd0);
        check("ovr_first_sample", {16'h0, sample}, {16'h0, HELD_WORD});
        check("ovr_first_ch", 32'(sample_ch), 32'(STEREO));
        t0 = cyc;
        for (n = 0; n < 300 && !overrun; n++) tick();
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_gap", 32'(cyc - t0), 32'(GAP));
        check("ovr_held_sample", {16'h0, sample}, {16'h0, HELD_WORD});
        check("ovr_held_valid", 32'(sample_valid), 32'd1);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        check("ovr_clr", 32'(overrun), 32'd0);
        check("ovr_clr_sample", {16'h0, sample}, {16'h0, HELD_WORD});
        sample_ready = 1'b1;
        tick();
        tick();
        check("ovr_drained", 32'(sample_valid), 32'd0);
        chk_en = 1'b1;

        // Drop enable mid left slot: finish the frame, then park.
        for (n = 0; n < 300 && !(rc > 64 && rc % 64 == 10); n++) tick();
        check("stop_sync", 32'(rc % 64), 32'd10);
        d0     = deliveries;
        enable = 1'b0;
        for (n = 0; n < 400 && busy; n++) tick();
        check("stop_idle", 32'(busy), 32'd0);
        check("stop_frame_end", 32'(last_rc % 64), 32'd0);
        check("stop_deliv", 32'(deliveries - d0), STEREO ? 32'd2 : 32'd1);
        repeat (10) tick();
        check("stop_parked", 32'({sck, ws, busy, sample_valid}), 32'd0);

        // Re-enable: warm-up repeats before the first delivery.
        t0     = cyc;
        d0     = deliveries;
        enable = 1'b1;
        for (n = 0; n < 600 && deliveries == d0; n++) tick();
        check("restart_latency", 32'(cyc - t0), 32'(FIRST_LAT));

        // Asynchronous reset in the middle of a left slot.
        for (n = 0; n < 400 && !(rc > 64 && rc % 64 == 20); n++) tick();
        check("pre_rst_sample", {16'h0, sample}, {16'h0, HELD_WORD});
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_flags", 32'({sck, ws, sample_ch, sample_valid, overrun, busy}), 32'd0);
        check("async_rst_sample", {16'h0, sample}, 32'd0);
        repeat (4) tick();
        t0    = cyc;
        d0    = deliveries;
        rst_n = 1'b1;
        for (n = 0; n < 600 && deliveries == d0; n++) tick();
        check("post_rst_latency", 32'(cyc - t0), 32'(FIRST_LAT));
        check("post_rst_deliv", 32'(deliveries - d0), 32'd1);

        chk_en = 1'b0;
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
